// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected layer control blocks.
package fc_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 11;
    localparam int unsigned DefPeLatency = 4;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StHold
    } fc_state_e;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Signal bundle between the sequencer, its controller, the layer/ROM and the consumer.
interface fc_layer_sequencer_if #(
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned AddrWidth   = 11,
    parameter int unsigned OutputNodes = 32
);
    logic                               start;
    logic                               busy;
    logic                               done;
    logic [AddrWidth-1:0]               address;
    logic                               pe_reset;
    logic [AddrWidth-1:0]               weight_addr;
    logic                               weight_rd_en;
    logic [DataWidth*OutputNodes-1:0]   fc_result;
    logic [DataWidth*OutputNodes-1:0]   out_data;
    logic                               out_valid;
    logic                               out_ready;

    // Sequencer side.
    modport master (
        input  start, fc_result, out_ready,
        output busy, done, address, pe_reset, weight_addr, weight_rd_en, out_data, out_valid
    );

    // Environment side: controller, layer, ROM and result consumer.
    modport slave (
        output start, fc_result, out_ready,
        input  busy, done, address, pe_reset, weight_addr, weight_rd_en, out_data, out_valid
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Sequences one fully-connected layer evaluation: clear PEs, stream input indices
// with matching weight-ROM reads, wait out the PE pipeline, then hand the captured
// output vector downstream over valid/ready.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int unsigned DataWidth   = DefDataWidth,
    parameter int unsigned InputNodes  = 100,
    parameter int unsigned OutputNodes = 32,
    parameter int unsigned PeLatency   = DefPeLatency,
    parameter int unsigned AddrWidth   = DefAddrWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    fc_layer_sequencer_if.master  bus_io
);

    localparam int unsigned              DrainWidth = $clog2(PeLatency + 2);
    localparam int unsigned              VecWidth   = DataWidth * OutputNodes;
    // Out-of-range index: the layer feeds zero so the accumulators hold.
    localparam logic [AddrWidth-1:0]     IdleAddr   = AddrWidth'(InputNodes);
    localparam logic [AddrWidth-1:0]     LastAddr   = AddrWidth'(InputNodes - 1);
    localparam logic [DrainWidth-1:0]    DrainInit  = DrainWidth'(PeLatency);

    fc_state_e               state_q, state_d;
    logic [AddrWidth-1:0]    k_q, k_d;
    logic [DrainWidth-1:0]   drain_q, drain_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pe_reset_q, pe_reset_d;
    logic [AddrWidth-1:0]    address_q, address_d;
    logic [AddrWidth-1:0]    weight_addr_q, weight_addr_d;
    logic                    weight_rd_en_q, weight_rd_en_d;
    logic [VecWidth-1:0]     out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    // Next-state and registered-output values; outputs are decided for the next state.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        drain_d        = drain_q;
        done_d         = 1'b0;
        address_d      = IdleAddr;
        weight_addr_d  = weight_addr_q;
        weight_rd_en_d = 1'b0;
        out_data_d     = out_data_q;
        out_valid_d    = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d        = StStream;
                k_d            = '0;
                address_d      = '0;
                weight_addr_d  = '0;
                weight_rd_en_d = 1'b1;
            end
            StStream: begin
                if (k_q == LastAddr) begin
                    state_d = StDrain;
                    drain_d = DrainInit;
                end else begin
                    k_d            = k_q + 1'b1;
                    address_d      = k_q + 1'b1;
                    weight_addr_d  = k_q + 1'b1;
                    weight_rd_en_d = 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == '0) begin
                    state_d     = StHold;
                    out_data_d  = bus_io.fc_result;
                    out_valid_d = 1'b1;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StHold: begin
                if (bus_io.out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d     = (state_d != StIdle);
        pe_reset_d = (state_d == StClear);
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            k_q            <= '0;
            drain_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pe_reset_q     <= 1'b0;
            address_q      <= IdleAddr;
            weight_addr_q  <= '0;
            weight_rd_en_q <= 1'b0;
            out_data_q     <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            drain_q        <= drain_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pe_reset_q     <= pe_reset_d;
            address_q      <= address_d;
            weight_addr_q  <= weight_addr_d;
            weight_rd_en_q <= weight_rd_en_d;
            out_data_q     <= out_data_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign bus_io.busy         = busy_q;
    assign bus_io.done         = done_q;
    assign bus_io.address      = address_q;
    assign bus_io.pe_reset     = pe_reset_q;
    assign bus_io.weight_addr  = weight_addr_q;
    assign bus_io.weight_rd_en = weight_rd_en_q;
    assign bus_io.out_data     = out_data_q;
    assign bus_io.out_valid    = out_valid_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer with a small layer + weight-ROM model around it.
module tb_fc_layer_sequencer;

    localparam int unsigned DW = 32;
    localparam int unsigned IN = 4;
    localparam int unsigned ON = 2;
    localparam int unsigned PL = 4;
    localparam int unsigned AW = 11;

    logic clk;
    logic rst_n;

    fc_layer_sequencer_if #(.DataWidth(DW), .AddrWidth(AW), .OutputNodes(ON)) bus ();

    fc_layer_sequencer #(
        .DataWidth   (DW),
        .InputNodes  (IN),
        .OutputNodes (ON),
        .PeLatency   (PL),
        .AddrWidth   (AW)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Values are kept in half-units so every sum is exact in single precision.
    int in_val [IN];      // input value (integer)
    int w_half [IN][ON];  // weight * 2

    // Non-negative integer count of half-units -> IEEE-754 single bits.
    function automatic logic [31:0] to_f32(input int n);
        int          p;
        logic [31:0] m;
        if (n <= 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 24; b++) if (n[b]) p = b;
        m = 32'(n) << (23 - p);
        return {1'b0, 8'(126 + p), m[22:0]};
    endfunction

    // Reference: dot products of the input vector with each weight column.
    function automatic logic [DW*ON-1:0] expected_vec();
        logic [DW*ON-1:0] v;
        v = '0;
        for (int j = 0; j < ON; j++) begin
            int s;
            s = 0;
            for (int i = 0; i < IN; i++) s += in_val[i] * w_half[i][j];
            v[j*DW +: DW] = to_f32(s);
        end
        return v;
    endfunction

    // Environment: layer registers its input a cycle after address, ROM reads
    // in one cycle, PE products reach the accumulator PL cycles after presentation.
    int x_q;
    int w_q  [ON];
    int pipe [PL-1][ON];
    int acc  [ON];

    always @(posedge clk) begin
        x_q <= (int'(bus.address) < IN) ? in_val[int'(bus.address)] : 0;
        if (bus.weight_rd_en && int'(bus.weight_addr) < IN)
            for (int j = 0; j < ON; j++) w_q[j] <= w_half[int'(bus.weight_addr)][j];
        for (int j = 0; j < ON; j++) begin
            if (bus.pe_reset) begin
                for (int s = 0; s < PL - 1; s++) pipe[s][j] <= 0;
                acc[j] <= 0;
            end else begin
                pipe[0][j] <= x_q * w_q[j];
                for (int s = 1; s < PL - 1; s++) pipe[s][j] <= pipe[s-1][j];
                acc[j] <= acc[j] + pipe[PL-2][j];
            end
        end
    end

    always_comb begin
        bus.fc_result = '0;
        for (int j = 0; j < ON; j++) bus.fc_result[j*DW +: DW] = to_f32(acc[j]);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full evaluation from the start pulse to the done pulse.
    task automatic do_run(input int ready_delay, input bit poke);
        logic [DW*ON-1:0] exp_vec;
        exp_vec = expected_vec();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_val("clear_busy", 64'(bus.busy), 64'd1);
        check_val("clear_pe_reset", 64'(bus.pe_reset), 64'd1);
        check_val("clear_addr", 64'(bus.address), 64'(IN));
        step();
        for (int k = 0; k < IN; k++) begin
            check_val("stream_addr", 64'(bus.address), 64'(k));
            check_val("stream_waddr", 64'(bus.weight_addr), 64'(k));
            check_val("stream_rd_en", 64'(bus.weight_rd_en), 64'd1);
            check_val("stream_pe_reset", 64'(bus.pe_reset), 64'd0);
            bus.start = poke && (k == 1);
            step();
        end
        bus.start = 1'b0;
        for (int d = 0; d <= PL; d++) begin
            check_val("drain_addr", 64'(bus.address), 64'(IN));
            check_val("drain_rd_en", 64'(bus.weight_rd_en), 64'd0);
            check_val("drain_valid", 64'(bus.out_valid), 64'd0);
            step();
        end
        // IN+PL+2 edges after the start-sampling edge.
        check_val("latency_valid", 64'(bus.out_valid), 64'd1);
        check_val("hold_data", 64'(bus.out_data), 64'(exp_vec));
        for (int c = 0; c < ready_delay; c++) begin
            bus.out_ready = 1'b0;
            bus.start     = poke;
            check_val("bp_valid", 64'(bus.out_valid), 64'd1);
            check_val("bp_done", 64'(bus.done), 64'd0);
            check_val("bp_data", 64'(bus.out_data), 64'(exp_vec));
            step();
        end
        bus.out_ready = 1'b1;
        bus.start     = poke;
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check_val("hs_done", 64'(bus.done), 64'd1);
        check_val("hs_valid", 64'(bus.out_valid), 64'd0);
        check_val("hs_busy", 64'(bus.busy), 64'd0);
        check_val("hs_data_kept", 64'(bus.out_data), 64'(exp_vec));
    endtask

    task automatic after_done();
        step();
        check_val("idle_done", 64'(bus.done), 64'd0);
        check_val("idle_busy", 64'(bus.busy), 64'd0);
        check_val("idle_addr", 64'(bus.address), 64'(IN));
        check_val("idle_pe_reset", 64'(bus.pe_reset), 64'd0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < IN; i++) begin
            in_val[i]    = i + 1;
            w_half[i][0] = 2;
            w_half[i][1] = 1;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        load_basic();
        step();
        step();
        check_val("rst_busy", 64'(bus.busy), 64'd0);
        check_val("rst_done", 64'(bus.done), 64'd0);
        check_val("rst_pe_reset", 64'(bus.pe_reset), 64'd0);
        check_val("rst_rd_en", 64'(bus.weight_rd_en), 64'd0);
        check_val("rst_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_data", 64'(bus.out_data), 64'd0);
        check_val("rst_addr", 64'(bus.address), 64'(IN));
        check_val("rst_waddr", 64'(bus.weight_addr), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic evaluation with fixed known result words.
        do_run(0, 1'b0);
        check_val("basic_word0", 64'(bus.out_data[31:0]), 64'h4120_0000);
        check_val("basic_word1", 64'(bus.out_data[63:32]), 64'h40A0_0000);
        after_done();

        // Backpressure, then start pokes during STREAM and HOLD.
        do_run(10, 1'b0);
        after_done();
        do_run(3, 1'b1);
        after_done();

        // Reset in the middle of STREAM at k=2.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        step();
        check_val("abort_addr_k2", 64'(bus.address), 64'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_val("abort_addr", 64'(bus.address), 64'(IN));
        check_val("abort_valid", 64'(bus.out_valid), 64'd0);
        check_val("abort_busy", 64'(bus.busy), 64'd0);
        check_val("abort_data", 64'(bus.out_data), 64'd0);
        step();
        do_run(1, 1'b0);
        check_val("post_abort_word0", 64'(bus.out_data[31:0]), 64'h4120_0000);
        check_val("post_abort_word1", 64'(bus.out_data[63:32]), 64'h40A0_0000);

        // Back-to-back: start in the done cycle with new operands.
        for (int i = 0; i < IN; i++) begin
            in_val[i]    = 2;
            w_half[i][0] = 2;
            w_half[i][1] = 2;
        end
        do_run(0, 1'b0);
        check_val("b2b_word0", 64'(bus.out_data[31:0]), 64'h4100_0000);
        after_done();

        // Randomized operands, backpressure and start pokes.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < IN; i++) begin
                in_val[i] = int'($urandom_range(0, 9));
                for (int j = 0; j < ON; j++) w_half[i][j] = int'($urandom_range(0, 8));
            end
            do_run(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) after_done();
        end
        after_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
